// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, jump-field bit positions and
// the PC stage state encoding.
package cpu_pkg;

  localparam int PC_W   = 16;
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/jump_cond.sv
// Hack C-instruction jump condition: resolves the j-bits against the
// zero/negative flags of the current ALU result.
module jump_cond
  import cpu_pkg::*;
(
  input  logic       zr_i,
  input  logic       ng_i,
  input  logic       is_c_i,
  input  logic [2:0] jmp_i,
  output logic       take_o
);

  logic pos;

  assign pos    = ~ng_i & ~zr_i;
  assign take_o = is_c_i & ((jmp_i[JMP_LT] & ng_i) |
                            (jmp_i[JMP_EQ] & zr_i) |
                            (jmp_i[JMP_GT] & pos));

endmodule

// File: rtl/or8way.sv
// 8-input OR reduction from the Hack gate library.
module or8way (
  input  logic [7:0] in_i,
  output logic       out_o
);

  assign out_o = |in_i;

endmodule

// File: rtl/pc_jump_unit.sv
// Program counter with jump resolution and self-loop halt detection.
// Only WIDTH=16 is supported: zero detect is built from two or8way slices.
module pc_jump_unit
  import cpu_pkg::*;
#(
  parameter int          WIDTH        = 16,
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          HALT_COUNT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             is_c,
  input  logic [2:0]       jmp,
  input  logic [WIDTH-1:0] a_reg,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             zr_q,
  output logic             ng_q,
  output logic             jump_taken,
  output logic             halted
);

  localparam int CNT_W = (HALT_COUNT < 1) ? 1 : $clog2(HALT_COUNT + 1);
  localparam bit HALT_EN = (HALT_COUNT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HALT_COUNT > 0) ? HALT_COUNT - 1 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             zr_d, ng_d;
  logic             jt_q, jt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic or_lo, or_hi, zr, ng, take, self_jmp;

  or8way u_or_lo (.in_i(alu_out[7:0]),  .out_o(or_lo));
  or8way u_or_hi (.in_i(alu_out[15:8]), .out_o(or_hi));

  assign zr = ~(or_lo | or_hi);
  assign ng = alu_out[WIDTH-1];

  jump_cond u_jump_cond (
    .zr_i   (zr),
    .ng_i   (ng),
    .is_c_i (is_c),
    .jmp_i  (jmp),
    .take_o (take)
  );

  assign self_jmp = take & (a_reg == pc_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    jt_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ce) begin
          pc_d = take ? a_reg : pc_q + WIDTH'(1);
          jt_d = take;
          if (is_c) begin
            zr_d = zr;
            ng_d = ng;
          end
          if (HALT_EN) begin
            // The halting edge still lands pc on a_reg, which is pc itself.
            if (self_jmp && cnt_q == CNT_LAST) begin
              state_d = ST_HALTED;
              cnt_d   = '0;
              jt_d    = 1'b0;
            end else if (self_jmp) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              cnt_d = '0;
            end
          end
        end
      end
      ST_HALTED: begin
        if (resume) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      jt_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      jt_q    <= jt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc         = pc_q;
  assign jump_taken = jt_q;
  assign halted     = (state_q == ST_HALTED);

endmodule

// File: doc/pc_jump_unit.md
Name: pc_jump_unit

Overview:
- Program-counter and jump-resolution stage of the Hack-style CPU.
- Sits directly downstream of the zero-detect logic: it reduces the 16-bit ALU result to zr/ng using two or8way instances, decodes the C-instruction jump bits and selects the next PC.
- Also detects the "@END; 0;JMP" self-loop idiom and parks the core in a HALTED state for the FPGA debug LEDs.

Parameters:
- WIDTH, 16, data/PC width. The zero reduction is fixed at two or8way slices, so WIDTH=16 is the only supported value.
- RESET_VECTOR, 16'h0000, PC value after reset.
- HALT_COUNT, 4, consecutive self-jumps needed to enter HALTED. A value of 0 disables halt detection.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  clock enable; 0 = stall, so all state holds.
- alu_out  input  16  ALU result for the current instruction.
- is_c  input  1  current instruction is a C-instruction.
- jmp  input  3  jump bits {j2 lt, j1 eq, j0 gt}.
- a_reg  input  16  jump target (A register).
- resume  input  1  leave HALTED (single-cycle pulse).
- pc  output  16  current instruction address (registered).
- zr_q  output  1  registered zero flag.
- ng_q  output  1  registered negative flag.
- jump_taken  output  1  high for one cycle after a taken jump.
- halted  output  1  high while in HALTED.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n). Reset forces pc=RESET_VECTOR, zr_q=0, ng_q=0, jump_taken=0, halted=0, loop_cnt=0, state=RUN, regardless of ce.
- Combinational flags: zr = ~(or8way(alu_out[7:0]) | or8way(alu_out[15:8])); ng = alu_out[15].
- Jump decision: take = is_c & ((jmp[2]&ng) | (jmp[1]&zr) | (jmp[0]&~ng&~zr)).
  - jmp=3'b111 is an unconditional jump.
  - jmp=3'b000 never jumps.
  - A-instructions (is_c=0) never jump.
- States:
  - RUN: on an edge with ce=1, pc <= take ? a_reg : pc+1. Increment wraps 16'hFFFF -> 16'h0000. zr_q/ng_q <= zr/ng when is_c=1, otherwise held. jump_taken <= take.
  - HALTED: pc, flags and loop_cnt frozen; jump_taken=0; halted=1. The is_c, jmp, alu_out and ce inputs are ignored except for the resume check below.
- ce=0 in RUN: pc, flags, loop_cnt and state hold. jump_taken <= 0.
- Halt detect (RUN, ce=1, HALT_COUNT>0):
  - self = take & (a_reg == pc).
  - If self and loop_cnt == HALT_COUNT-1: state <= HALTED, loop_cnt <= 0. pc <= a_reg, which equals pc. halted rises on that same edge.
  - Else if self: loop_cnt++.
  - Else: loop_cnt <= 0.
- loop_cnt width: $clog2(HALT_COUNT+1), minimum 1.
- Resume:
  - In HALTED, resume=1 on an edge sets state <= RUN with pc unchanged and loop_cnt=0. It takes effect regardless of ce. Execution continues from the same pc, so a genuine loop re-halts after HALT_COUNT cycles.
  - resume in RUN is ignored.
- Reset mid-operation: asynchronous assertion overrides any state, including HALTED. The first edge after deassertion behaves as RUN from RESET_VECTOR.
- Latency: a decision made in cycle N is visible on pc in cycle N+1. There are no bubbles.

Decomposition:
- Shared package cpu_pkg:
  - Constants: PC_W=16, JMP_LT=2, JMP_EQ=1, JMP_GT=0.
  - State encoding: ST_RUN=1'b0, ST_HALTED=1'b1.
  - Jump-field bit positions.
- Sub-modules:
  - Reuse the existing or8way for the two zero-detect slices; do not re-implement it.
  - One natural new sub-module: jump_cond (combinational: zr, ng, is_c, jmp -> take). It is shared later with the CPU decode stage.

Test Plan:
- Reset/increment: rst_n=0 then 1, ce=1, is_c=0 for 3 edges -> pc 0,1,2,3; zr_q=0, ng_q=0, halted=0.
- Conditional jumps:
  - alu_out=16'h0000, jmp=3'b010, a_reg=16'h0040 -> pc=16'h0040, zr_q=1, jump_taken=1 for one cycle.
  - alu_out=16'h8001, jmp=3'b001 -> pc+1, ng_q=1, jump_taken=0.
  - alu_out=16'h8001, jmp=3'b100 -> jump taken.
- Zero-detect slices: alu_out=16'h0100 with jmp=3'b010 -> no jump (exercises the high or8way); alu_out=16'h0001 -> no jump; alu_out=0 -> jump.
- Stall and wrap:
  - pc=16'hFFFF, is_c=0, ce=0 for 2 edges -> pc stays 16'hFFFF; jump_taken=0.
  - Then ce=1 -> pc=16'h0000.
- Halt/resume:
  - pc=16'h0010, a_reg=16'h0010, is_c=1, jmp=3'b111, HALT_COUNT=4 -> halted=1 after the 4th edge, pc stays 16'h0010.
  - ce toggling and further jumps while HALTED -> no change.
  - resume pulse -> halted=0; halted re-asserts 4 edges later.
- Async reset in HALTED: drop rst_n between edges -> pc=16'h0000 and halted=0 immediately, without waiting for a clock edge.
